// File: rtl/servocount_multi_if.sv
// Scan/measurement bus of servocount_multi: servo inputs, scan control and status.
// The host side drives the master modport; the counter block uses slave.
interface servocount_multi_if #(
    parameter int NCH = 4
) ();
    logic [NCH-1:0] in_i;
    logic           scan_en_i;
    logic           scan_in_i;
    logic           scan_out_o;
    logic           all_done_o;

    modport master (
        output in_i,
        output scan_en_i,
        output scan_in_i,
        input  scan_out_o,
        input  all_done_o
    );

    modport slave (
        input  in_i,
        input  scan_en_i,
        input  scan_in_i,
        output scan_out_o,
        output all_done_o
    );
endinterface

// File: rtl/servocount_multi.sv
// Multi-channel servo pulse-width counter with a daisy-chained scan readout/clear path.
// Optional majority glitch filter on each input: define SERVOCOUNT_GLITCH_FILTER_EN.
module servocount_multi #(
    parameter int NCH      = 4,
    parameter int WIDTH    = 12,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    servocount_multi_if.slave   bus
);

    typedef enum logic [1:0] {
        WAIT     = 2'b00,
        RUNNING  = 2'b01,
        DONE     = 2'b10,
        OVERFLOW = 2'b11
    } state_e;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef SERVOCOUNT_GLITCH_FILTER_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif

    logic [SYNC-1:0]  sync_q  [NCH];
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [NCH-1:0]   rise, fall, chainIn, doneBits;

`ifdef SERVOCOUNT_GLITCH_FILTER_EN
    logic [NCH-1:0]   filt;
    logic [NCH-1:0]   filtPrev_q;

    // Edges are taken on the majority-voted level, so a lone odd sample never toggles it.
    always_comb begin
        filt = '0;
        rise = '0;
        fall = '0;
        for (int i = 0; i < NCH; i++) begin
            filt[i] = (sync_q[i][0] & sync_q[i][1]) |
                      (sync_q[i][0] & sync_q[i][2]) |
                      (sync_q[i][1] & sync_q[i][2]);
            rise[i] = filt[i] & ~filtPrev_q[i];
            fall[i] = ~filt[i] & filtPrev_q[i];
        end
    end
`else
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < NCH; i++) begin
            rise[i] = sync_q[i][0] & ~sync_q[i][1];
            fall[i] = ~sync_q[i][0] & sync_q[i][1];
        end
    end
`endif

    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Each channel's chain input is the state MSB of the channel below it.
    always_comb begin
        chainIn    = '0;
        doneBits   = '0;
        chainIn[0] = bus.scan_in_i;
        for (int i = 1; i < NCH; i++) begin
            chainIn[i] = state_q[i-1][1];
        end
        for (int i = 0; i < NCH; i++) begin
            doneBits[i] = state_q[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (bus.scan_en_i) begin
                count_d[i] = {count_q[i][WIDTH-2:0], chainIn[i]};
                state_d[i] = state_e'({state_q[i][0], count_q[i][WIDTH-1]});
            end else begin
                case (state_q[i])
                    WAIT: begin
                        if (rise[i]) begin
                            state_d[i] = RUNNING;
                        end
                    end
                    RUNNING: begin
                        if (tick) begin
                            count_d[i] = count_q[i] + WIDTH'(1);
                        end
                        if (fall[i]) begin
                            state_d[i] = DONE;
                        end else if (tick && (&count_q[i])) begin
                            state_d[i] = OVERFLOW;
                        end
                    end
                    DONE, OVERFLOW: begin
                    end
                    default: begin
                        state_d[i] = WAIT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= WAIT;
                count_q[i] <= '0;
            end
`ifdef SERVOCOUNT_GLITCH_FILTER_EN
            filtPrev_q <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            for (int i = 0; i < NCH; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC-2:0], bus.in_i[i]};
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
`ifdef SERVOCOUNT_GLITCH_FILTER_EN
            filtPrev_q <= filt;
`endif
        end
    end

    assign bus.scan_out_o = state_q[NCH-1][1];
    assign bus.all_done_o = &doneBits;

endmodule

// File: tb/tb_servocount_multi.sv
// Self-checking bench for servocount_multi: two configurations checked every cycle
// against a sequence-level model, plus hand-computed scan readout expectations.
module tb_servocount_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    servocount_multi_if #(.NCH(4)) busA ();
    servocount_multi_if #(.NCH(2)) busB ();

    servocount_multi #(.NCH(4), .WIDTH(12), .PRESCALE(1)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    servocount_multi #(.NCH(2), .WIDTH(8), .PRESCALE(4)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    int checks = 0;
    int errors = 0;

    int cfgN [2] = '{4, 2};
    int cfgW [2] = '{12, 8};
    int cfgP [2] = '{1, 4};

    int mState [2][4];
    int mCount [2][4];
    bit mSamp  [2][4][3];
    bit mPrev  [2][4];
    int mPresc [2];
    bit modelValid = 1'b0;

    bit rdBits [64];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Model: channels seen as one flat bit sequence during scan, plain counters otherwise.
    task automatic modelStep(input int d, input bit r, input bit [3:0] inv, input bit se, input bit si);
        int n, w, len, base;
        bit tick, lvl, prv;
        bit rise [4];
        bit fall [4];
        bit flat [64];
        n   = cfgN[d];
        w   = cfgW[d];
        len = n * (w + 2);
        if (r) begin
            mPresc[d] = 0;
            for (int c = 0; c < 4; c++) begin
                mState[d][c] = 0;
                mCount[d][c] = 0;
                mPrev[d][c]  = 1'b0;
                for (int k = 0; k < 3; k++) mSamp[d][c][k] = 1'b0;
            end
            return;
        end
        tick      = (mPresc[d] == cfgP[d] - 1);
        mPresc[d] = (mPresc[d] + 1) % cfgP[d];
        for (int c = 0; c < n; c++) begin
`ifdef SERVOCOUNT_GLITCH_FILTER_EN
            lvl = (int'(mSamp[d][c][0]) + int'(mSamp[d][c][1]) + int'(mSamp[d][c][2])) >= 2;
            prv = mPrev[d][c];
            mPrev[d][c] = lvl;
`else
            lvl = mSamp[d][c][0];
            prv = mSamp[d][c][1];
`endif
            rise[c] = lvl && !prv;
            fall[c] = !lvl && prv;
            mSamp[d][c][2] = mSamp[d][c][1];
            mSamp[d][c][1] = mSamp[d][c][0];
            mSamp[d][c][0] = inv[c];
        end
        if (se) begin
            for (int j = 0; j < n; j++) begin
                base = j * (w + 2);
                flat[base]     = mState[d][n-1-j][1];
                flat[base + 1] = mState[d][n-1-j][0];
                for (int b = 0; b < w; b++) flat[base + 2 + b] = mCount[d][n-1-j][w-1-b];
            end
            for (int k = 0; k < len - 1; k++) flat[k] = flat[k+1];
            flat[len-1] = si;
            for (int j = 0; j < n; j++) begin
                base = j * (w + 2);
                mState[d][n-1-j] = 2 * int'(flat[base]) + int'(flat[base + 1]);
                mCount[d][n-1-j] = 0;
                for (int b = 0; b < w; b++)
                    mCount[d][n-1-j] = (mCount[d][n-1-j] << 1) | int'(flat[base + 2 + b]);
            end
        end else begin
            for (int c = 0; c < n; c++) begin
                if (mState[d][c] == 0) begin
                    if (rise[c]) mState[d][c] = 1;
                end else if (mState[d][c] == 1) begin
                    bit carry;
                    carry = tick && (mCount[d][c] == (1 << w) - 1);
                    if (tick) mCount[d][c] = (mCount[d][c] + 1) % (1 << w);
                    if (fall[c]) mState[d][c] = 2;
                    else if (carry) mState[d][c] = 3;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        modelStep(0, rst, 4'(busA.in_i), busA.scan_en_i, busA.scan_in_i);
        modelStep(1, rst, {2'b00, busB.in_i}, busB.scan_en_i, busB.scan_in_i);
        if (rst) modelValid = 1'b1;
    end

    function automatic int expAllDone(input int d);
        int ok;
        ok = 1;
        for (int c = 0; c < cfgN[d]; c++) if (mState[d][c] < 2) ok = 0;
        return ok;
    endfunction

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("scanOutA", int'(busA.scan_out_o), mState[0][3] / 2);
            checkOutput("allDoneA", int'(busA.all_done_o), expAllDone(0));
            checkOutput("scanOutB", int'(busB.scan_out_o), mState[1][1] / 2);
            checkOutput("allDoneB", int'(busB.all_done_o), expAllDone(1));
        end
    end

    task automatic setIn(input int d, input bit [3:0] bits);
        if (d == 0) busA.in_i = bits;
        else        busB.in_i = bits[1:0];
    endtask

    task automatic applyStimulus(input int d, input int w0, input int w1, input int w2, input int w3);
        int widths [4];
        int maxw;
        bit [3:0] bits;
        widths = '{w0, w1, w2, w3};
        maxw = 0;
        for (int c = 0; c < 4; c++) if (widths[c] > maxw) maxw = widths[c];
        for (int t = 0; t < maxw; t++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) bits[c] = (t < widths[c]);
            setIn(d, bits);
        end
        @(negedge clk);
        setIn(d, 4'b0000);
        repeat (6) @(negedge clk);
    endtask

    // Reads the whole chain while shifting zeros in, which also clears every channel.
    task automatic readChain(input int d);
        int len;
        len = cfgN[d] * (cfgW[d] + 2);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (d == 0) begin
                rdBits[k] = busA.scan_out_o;
                busA.scan_en_i = 1'b1;
                busA.scan_in_i = 1'b0;
            end else begin
                rdBits[k] = busB.scan_out_o;
                busB.scan_en_i = 1'b1;
                busB.scan_in_i = 1'b0;
            end
        end
        @(negedge clk);
        busA.scan_en_i = 1'b0;
        busB.scan_en_i = 1'b0;
    endtask

    function automatic int chainWord(input int d, input int ch);
        int base, v;
        base = (cfgN[d] - 1 - ch) * (cfgW[d] + 2);
        v = 0;
        for (int b = 0; b < cfgW[d] + 2; b++) v = (v << 1) | int'(rdBits[base + b]);
        return v;
    endfunction

    initial begin
        int cnt;
        rst = 1'b1;
        busA.in_i = '0; busA.scan_en_i = 1'b0; busA.scan_in_i = 1'b0;
        busB.in_i = '0; busB.scan_en_i = 1'b0; busB.scan_in_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetScanOutA", int'(busA.scan_out_o), 0);
        checkOutput("resetAllDoneA", int'(busA.all_done_o), 0);
        checkOutput("resetAllDoneB", int'(busB.all_done_o), 0);
        rst = 1'b0;

        readChain(0);
        applyStimulus(0, 100, 0, 0, 0);
        checkOutput("modelPinCh0Count", mCount[0][0], 100);
        checkOutput("singleAllDone", int'(busA.all_done_o), 0);
        readChain(0);
        checkOutput("singleCh0Word", chainWord(0, 0), (2 << 12) | 100);
        checkOutput("singleCh1Word", chainWord(0, 1), 0);
        checkOutput("singleCh2Word", chainWord(0, 2), 0);
        checkOutput("singleCh3Word", chainWord(0, 3), 0);

        applyStimulus(0, 10, 20, 30, 40);
        checkOutput("multiAllDone", int'(busA.all_done_o), 1);
        readChain(0);
        checkOutput("multiCh3Word", chainWord(0, 3), (2 << 12) | 40);
        checkOutput("multiCh2Word", chainWord(0, 2), (2 << 12) | 30);
        checkOutput("multiCh1Word", chainWord(0, 1), (2 << 12) | 20);
        checkOutput("multiCh0Word", chainWord(0, 0), (2 << 12) | 10);
        checkOutput("multiClearedAllDone", int'(busA.all_done_o), 0);

        applyStimulus(0, 0, 400, 0, 0);
        readChain(0);
        checkOutput("p1Ch1Word", chainWord(0, 1), (2 << 12) | 400);

        applyStimulus(1, 0, 400, 0, 0);
        readChain(1);
        cnt = chainWord(1, 1) & 8'hFF;
        checkOutput("p4Ch1State", chainWord(1, 1) >> 8, 2);
        checkOutput("p4Ch1CountInRange", int'(cnt == 100 || cnt == 101), 1);

        applyStimulus(1, 1200, 0, 0, 0);
        checkOutput("ovfModelPinState", mState[1][0], 3);
        readChain(1);
        checkOutput("ovfCh0Word", chainWord(1, 0), (3 << 8) | 0);

        @(negedge clk);
        setIn(0, 4'b0001);
        repeat (59) @(negedge clk);
        checkOutput("modelPinCount57", mCount[0][0], 57);
        rst = 1'b1;
        setIn(0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstScanOut", int'(busA.scan_out_o), 0);
        checkOutput("midRstModelState", mState[0][0], 0);
        applyStimulus(0, 25, 0, 0, 0);
        readChain(0);
        checkOutput("postRstCh0Word", chainWord(0, 0), (2 << 12) | 25);

`ifdef SERVOCOUNT_GLITCH_FILTER_EN
        @(negedge clk);
        setIn(0, 4'b0100);
        @(negedge clk);
        setIn(0, 4'b0000);
        repeat (8) @(negedge clk);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            setIn(0, (t == 50) ? 4'b0000 : 4'b0001);
        end
        @(negedge clk);
        setIn(0, 4'b0000);
        repeat (8) @(negedge clk);
        readChain(0);
        checkOutput("glitchHighCh2Word", chainWord(0, 2), 0);
        checkOutput("glitchLowCh0Word", chainWord(0, 0), (2 << 12) | 100);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
